// File: rtl/spi_arbiter.sv
// Arbitrates several requesters onto one spi_core, one latched transaction at a time.
// Build option: SPI_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module spi_arbiter #(
   parameter int unsigned REQUESTERS = 2,
   parameter int unsigned SLAVES     = 1,
   parameter int unsigned D_WIDTH    = 8,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned DIV_W      = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [REQUESTERS-1:0]        req,
   input  logic [REQUESTERS*ADDR_W-1:0] req_addr,
   input  logic [REQUESTERS*D_WIDTH-1:0] req_tx_data,
   input  logic [REQUESTERS*2-1:0]      req_mode,
   input  logic [REQUESTERS*DIV_W-1:0]  req_clk_div,
   output logic [REQUESTERS-1:0]        gnt,
   output logic [REQUESTERS-1:0]        done,
   output logic [REQUESTERS-1:0]        err,
   output logic [D_WIDTH-1:0]           rx_data,
   output logic                         core_enable,
   output logic                         core_cpol,
   output logic                         core_cpha,
   output logic                         core_cont,
   output logic [ADDR_W-1:0]            core_addr,
   output logic [DIV_W-1:0]             core_clk_div,
   output logic [D_WIDTH-1:0]           core_tx_data,
   input  logic                         core_busy,
   input  logic [D_WIDTH-1:0]           core_rx_data
);

   localparam int unsigned IDX_W        = $clog2(REQUESTERS);
   localparam int unsigned CNT_W        = 2;
   localparam int unsigned BUSY_TIMEOUT = 4;

   if (REQUESTERS < 2 || REQUESTERS > 8 || SLAVES < 1) begin : g_param_check
      $error("spi_arbiter: REQUESTERS must be 2..8 and SLAVES at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_COMPLETE
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    busy_cnt;
   logic [IDX_W-1:0]    win_c;
   logic                any_c;
   logic [ADDR_W-1:0]   sel_addr_c;
   logic [D_WIDTH-1:0]  sel_tx_c;
   logic [1:0]          sel_mode_c;
   logic [DIV_W-1:0]    sel_div_c;

`ifndef SPI_ARBITER_FIXED_PRIO_EN
   logic [IDX_W-1:0]    last_ptr;
`endif

   assign core_cont = 1'b0;
   assign any_c     = |req;

   // Winner selection and mux of the winner's request fields.
   always_comb begin
      win_c      = '0;
      sel_addr_c = '0;
      sel_tx_c   = '0;
      sel_mode_c = '0;
      sel_div_c  = '0;
`ifdef SPI_ARBITER_FIXED_PRIO_EN
      for (int k = REQUESTERS - 1; k >= 0; k--) begin
         if (req[IDX_W'(k)]) win_c = IDX_W'(k);
      end
`else
      // Descending scan so the nearest index after last_ptr is written last.
      for (int k = REQUESTERS; k >= 1; k--) begin
         int j;
         j = (int'(last_ptr) + k) % int'(REQUESTERS);
         if (req[IDX_W'(j)]) win_c = IDX_W'(j);
      end
`endif
      for (int k = 0; k < REQUESTERS; k++) begin
         if (IDX_W'(k) == win_c) begin
            sel_addr_c = req_addr[k*ADDR_W +: ADDR_W];
            sel_tx_c   = req_tx_data[k*D_WIDTH +: D_WIDTH];
            sel_mode_c = req_mode[k*2 +: 2];
            sel_div_c  = req_clk_div[k*DIV_W +: DIV_W];
         end
      end
   end

   // Transaction sequencer; every output is registered here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         busy_cnt     <= '0;
         gnt          <= '0;
         done         <= '0;
         err          <= '0;
         rx_data      <= '0;
         core_enable  <= 1'b0;
         core_cpol    <= 1'b0;
         core_cpha    <= 1'b0;
         core_addr    <= '0;
         core_clk_div <= '0;
         core_tx_data <= '0;
`ifndef SPI_ARBITER_FIXED_PRIO_EN
         last_ptr     <= IDX_W'(REQUESTERS - 1);
`endif
      end else begin
         done        <= '0;
         err         <= '0;
         core_enable <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_c && !core_busy) begin
                  gnt          <= REQUESTERS'(1) << win_c;
                  core_addr    <= sel_addr_c;
                  core_tx_data <= sel_tx_c;
                  core_cpol    <= sel_mode_c[1];
                  core_cpha    <= sel_mode_c[0];
                  core_clk_div <= sel_div_c;
                  core_enable  <= 1'b1;
`ifndef SPI_ARBITER_FIXED_PRIO_EN
                  last_ptr     <= win_c;
`endif
                  state        <= S_START;
               end
            end
            S_START: begin
               busy_cnt <= '0;
               state    <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (core_busy) begin
                  state <= S_WAIT_DONE;
               end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                  err   <= gnt;
                  gnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!core_busy) begin
                  rx_data <= core_rx_data;
                  state   <= S_COMPLETE;
               end
            end
            S_COMPLETE: begin
               done  <= gnt;
               gnt   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter with a behavioural loopback spi_core and a result scoreboard.
module tb_spi_arbiter;
   localparam int unsigned R  = 2;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned VW = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic [R-1:0]    req;
   logic [R*AW-1:0] req_addr;
   logic [R*DW-1:0] req_tx_data;
   logic [R*2-1:0]  req_mode;
   logic [R*VW-1:0] req_clk_div;
   logic [R-1:0]    gnt, done, err;
   logic [DW-1:0]   rx_data;
   logic            core_enable, core_cpol, core_cpha, core_cont;
   logic [AW-1:0]   core_addr;
   logic [VW-1:0]   core_clk_div;
   logic [DW-1:0]   core_tx_data;
   logic            core_busy;
   logic [DW-1:0]   core_rx_data;

   spi_arbiter #(.REQUESTERS(R), .SLAVES(1), .D_WIDTH(DW), .ADDR_W(AW), .DIV_W(VW)) dut (
      .clock(clock), .reset(reset), .req(req), .req_addr(req_addr),
      .req_tx_data(req_tx_data), .req_mode(req_mode), .req_clk_div(req_clk_div),
      .gnt(gnt), .done(done), .err(err), .rx_data(rx_data),
      .core_enable(core_enable), .core_cpol(core_cpol), .core_cpha(core_cpha),
      .core_cont(core_cont), .core_addr(core_addr), .core_clk_div(core_clk_div),
      .core_tx_data(core_tx_data), .core_busy(core_busy), .core_rx_data(core_rx_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      bit            is_err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   core_hold  = 1'b0;
   bit   core_stuck = 1'b0;

   // Loopback core: busy for three cycles after enable, then returns the word it was sent.
   initial begin
      int            cnt;
      logic [DW-1:0] lat;
      cnt = 0;
      lat = '0;
      core_busy    = 1'b0;
      core_rx_data = '0;
      forever begin
         @(posedge clock);
         #1;
         if (core_hold) begin
            core_busy = 1'b1;
            cnt       = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               core_busy    = 1'b0;
               core_rx_data = lat;
            end
         end else if (core_enable && !core_stuck) begin
            core_busy = 1'b1;
            cnt       = 3;
            lat       = core_tx_data;
         end else begin
            core_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] m, input logic [VW-1:0] v);
      req_addr[i*AW +: AW]    = a;
      req_tx_data[i*DW +: DW] = d;
      req_mode[i*2 +: 2]      = m;
      req_clk_div[i*VW +: VW] = v;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req   = '0;
      tick;
      tick;
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset;
      set_req(0, 4'hF, 8'hFF, 2'b11, 8'hFF);
      set_req(1, 4'hF, 8'hFF, 2'b11, 8'hFF);
      do_reset;
      checks++;
      if (gnt !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin
         errors++;
         $display("FAIL reset_handshake gnt=%b done=%b err=%b expected all 0", gnt, done, err);
      end
      checks++;
      if (rx_data !== 8'h00 || core_enable !== 1'b0 || core_cont !== 1'b0) begin
         errors++;
         $display("FAIL reset_core rx=%h en=%b cont=%b expected 0", rx_data, core_enable, core_cont);
      end
      checks++;
      if (core_addr !== 4'h0 || core_tx_data !== 8'h00 || core_clk_div !== 8'h00 ||
          core_cpol !== 1'b0 || core_cpha !== 1'b0) begin
         errors++;
         $display("FAIL reset_config addr=%h tx=%h div=%h cpol=%b cpha=%b expected 0",
                  core_addr, core_tx_data, core_clk_div, core_cpol, core_cpha);
      end
   endtask

   task automatic test_single;
      int   en_cycles = 0;
      int   gnt_bad   = 0;
      bit   seen      = 1'b0;
      bit   fin       = 1'b0;
      exp_t e;
      do_reset;
      set_req(0, 4'h1, 8'hA5, 2'b00, 8'd2);
      req = 2'b01;
      sb.push_back('{0, 8'hA5, 1'b0});
      for (int t = 0; t < 40 && !fin; t++) begin
         tick;
         if (core_enable) en_cycles++;
         if (done !== 2'b00) begin
            e = sb.pop_front();
            checks++;
            if (done !== R'(1) << e.idx || rx_data !== e.data || gnt !== 2'b00) begin
               errors++;
               $display("FAIL single_done done=%b rx=%h gnt=%b expected done=%b rx=%h gnt=00",
                        done, rx_data, gnt, R'(1) << e.idx, e.data);
            end
            fin = 1'b1;
         end else if (gnt !== 2'b00) begin
            seen = 1'b1;
            req  = 2'b00;
            if (gnt !== 2'b01) gnt_bad++;
         end else if (seen) begin
            gnt_bad++;
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL single_timeout got no done expected done[0]");
      end
      checks++;
      if (en_cycles != 1) begin
         errors++;
         $display("FAIL single_enable cycles=%0d expected 1", en_cycles);
      end
      checks++;
      if (gnt_bad != 0) begin
         errors++;
         $display("FAIL single_gnt_held bad_cycles=%0d expected 0", gnt_bad);
      end
      checks++;
      if (core_addr !== 4'h1 || core_clk_div !== 8'd2 || core_tx_data !== 8'hA5) begin
         errors++;
         $display("FAIL single_config addr=%h div=%h tx=%h expected 1 02 a5",
                  core_addr, core_clk_div, core_tx_data);
      end
      tick;
      checks++;
      if (done !== 2'b00) begin
         errors++;
         $display("FAIL single_pulse done=%b expected 00", done);
      end
   endtask

   task automatic test_round_robin;
      int         n;
      int         got     = 0;
      logic [R-1:0] prev  = '0;
      exp_t       e;
`ifdef SPI_ARBITER_FIXED_PRIO_EN
      n = 3;
`else
      n = 4;
`endif
      do_reset;
      set_req(0, 4'h2, 8'h11, 2'b01, 8'd4);
      set_req(1, 4'h3, 8'h22, 2'b10, 8'd6);
      for (int i = 0; i < n; i++) begin
`ifdef SPI_ARBITER_FIXED_PRIO_EN
         sb.push_back('{0, 8'h11, 1'b0});
`else
         sb.push_back('{i % 2, (i % 2) ? 8'h22 : 8'h11, 1'b0});
`endif
      end
      req = 2'b11;
      for (int t = 0; t < 200 && got < n; t++) begin
         tick;
         if (gnt !== 2'b00 && prev === 2'b00) begin
            checks++;
            if ({core_cpol, core_cpha} !== (gnt[1] ? 2'b10 : 2'b01)) begin
               errors++;
               $display("FAIL rr_mode gnt=%b mode=%b%b", gnt, core_cpol, core_cpha);
            end
         end
         prev = gnt;
         if (done !== 2'b00) begin
            e = sb.pop_front();
            checks++;
            if (done !== R'(1) << e.idx || rx_data !== e.data) begin
               errors++;
               $display("FAIL rr_order n=%0d done=%b rx=%h expected done=%b rx=%h",
                        got, done, rx_data, R'(1) << e.idx, e.data);
            end
            got++;
            if (got == n) req = 2'b00;
         end
      end
      checks++;
      if (got != n) begin
         errors++;
         $display("FAIL rr_timeout completions=%0d expected %0d", got, n);
      end
   endtask

   task automatic test_err;
      int   en_t     = -1;
      int   err_t    = -1;
      bit   saw_done = 1'b0;
      exp_t e;
      do_reset;
      core_stuck = 1'b1;
      set_req(0, 4'h5, 8'h5A, 2'b00, 8'd2);
      req = 2'b01;
      sb.push_back('{0, 8'h00, 1'b1});
      for (int t = 0; t < 30 && err_t < 0; t++) begin
         tick;
         if (core_enable && en_t < 0) begin
            en_t = t;
            req  = 2'b00;
         end
         if (done !== 2'b00) saw_done = 1'b1;
         if (err !== 2'b00) begin
            err_t = t;
            e = sb.pop_front();
            checks++;
            if (err !== R'(1) << e.idx || gnt !== 2'b00) begin
               errors++;
               $display("FAIL err_pulse err=%b gnt=%b expected err=%b gnt=00", err, gnt, R'(1) << e.idx);
            end
         end
      end
      checks++;
      if (en_t < 0 || err_t < 0 || err_t - en_t != 5) begin
         errors++;
         $display("FAIL err_latency cycles=%0d expected 5", err_t - en_t);
      end
      for (int t = 0; t < 6; t++) begin
         tick;
         if (done !== 2'b00 || err !== 2'b00) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL err_extra_pulse saw extra done/err expected none");
      end
      core_stuck = 1'b0;
   endtask

   task automatic test_drop;
      bit   granted  = 1'b0;
      bit   fin      = 1'b0;
      int   gt       = 0;
      int   unstable = 0;
      exp_t e;
      do_reset;
      set_req(1, 4'h7, 8'hC3, 2'b11, 8'd3);
      req = 2'b10;
      sb.push_back('{1, 8'hC3, 1'b0});
      for (int t = 0; t < 40 && !fin; t++) begin
         tick;
         if (gnt !== 2'b00 && !granted) begin
            granted = 1'b1;
            gt      = t;
         end
         if (granted && t == gt + 1) begin
            req = 2'b00;
            set_req(1, 4'h9, 8'h3C, 2'b00, 8'd1);
         end
         if (granted && (core_tx_data !== 8'hC3 || core_addr !== 4'h7)) unstable++;
         if (done !== 2'b00) begin
            e = sb.pop_front();
            checks++;
            if (done !== R'(1) << e.idx || rx_data !== e.data) begin
               errors++;
               $display("FAIL drop_done done=%b rx=%h expected done=%b rx=%h",
                        done, rx_data, R'(1) << e.idx, e.data);
            end
            fin = 1'b1;
         end
      end
      checks++;
      if (!fin || unstable != 0) begin
         errors++;
         $display("FAIL drop_stable finished=%0d unstable_cycles=%0d expected 1 and 0", fin, unstable);
      end
   endtask

   task automatic test_busy_reset;
      int   bad = 0;
      bit   fin = 1'b0;
      exp_t e;
      core_hold = 1'b1;
      do_reset;
      set_req(0, 4'h4, 8'h77, 2'b00, 8'd2);
      req = 2'b01;
      sb.push_back('{0, 8'h77, 1'b0});
      for (int t = 0; t < 8; t++) begin
         tick;
         if (gnt !== 2'b00 || core_enable !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL busy_no_grant bad_cycles=%0d expected 0", bad);
      end
      core_hold = 1'b0;
      for (int t = 0; t < 40 && !fin; t++) begin
         tick;
         if (gnt !== 2'b00) req = 2'b00;
         if (done !== 2'b00) begin
            e = sb.pop_front();
            checks++;
            if (done !== R'(1) << e.idx || rx_data !== e.data) begin
               errors++;
               $display("FAIL busy_done done=%b rx=%h expected done=%b rx=%h",
                        done, rx_data, R'(1) << e.idx, e.data);
            end
            fin = 1'b1;
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL busy_timeout got no done after core_busy released");
      end
   endtask

   task automatic test_reset_mid;
      bit   granted = 1'b0;
      bit   extra   = 1'b0;
      bit   fin     = 1'b0;
      exp_t e;
      do_reset;
      set_req(0, 4'h2, 8'h96, 2'b00, 8'd2);
      req = 2'b01;
      for (int t = 0; t < 20 && !granted; t++) begin
         tick;
         if (gnt !== 2'b00) granted = 1'b1;
      end
      req = 2'b00;
      tick;
      tick;
      reset = 1'b1;
      tick;
      checks++;
      if (gnt !== 2'b00 || done !== 2'b00 || err !== 2'b00 || core_enable !== 1'b0 ||
          core_tx_data !== 8'h00 || core_addr !== 4'h0 || !granted) begin
         errors++;
         $display("FAIL midreset_outputs granted=%0d gnt=%b done=%b err=%b en=%b tx=%h addr=%h expected zeros",
                  granted, gnt, done, err, core_enable, core_tx_data, core_addr);
      end
      reset = 1'b0;
      sb.delete();
      for (int t = 0; t < 6; t++) begin
         tick;
         if (done !== 2'b00 || err !== 2'b00) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL midreset_pulse saw done/err after reset expected none");
      end
      set_req(0, 4'h6, 8'h4B, 2'b00, 8'd2);
      req = 2'b01;
      sb.push_back('{0, 8'h4B, 1'b0});
      for (int t = 0; t < 40 && !fin; t++) begin
         tick;
         if (gnt !== 2'b00) req = 2'b00;
         if (done !== 2'b00) begin
            e = sb.pop_front();
            checks++;
            if (done !== R'(1) << e.idx || rx_data !== e.data) begin
               errors++;
               $display("FAIL midreset_next done=%b rx=%h expected done=%b rx=%h",
                        done, rx_data, R'(1) << e.idx, e.data);
            end
            fin = 1'b1;
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL midreset_timeout no done for follow-up request");
      end
   endtask

   initial begin
      reset       = 1'b1;
      req         = '0;
      req_addr    = '0;
      req_tx_data = '0;
      req_mode    = '0;
      req_clk_div = '0;
      test_reset;
      test_single;
      test_round_robin;
      test_err;
      test_drop;
      test_busy_reset;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
